// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and helpers for the pipeline hazard controller.
//   - mdu_state_e : MDU occupancy FSM states (IDLE, BUSY)
//   - clog2       : ceiling log2, used to size the MDU down-counter
//   - mdu_cnt_w   : counter width for a given MDU latency (never below 1 bit)
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    if (v > 1) begin
      x = v - 1;
      while (x > 0) begin
        r = r + 1;
        x = x >> 1;
      end
    end
    return r;
  endfunction

  // The counter holds MDU_LATENCY-1 at most; latency 1 still needs one bit.
  function automatic int unsigned mdu_cnt_w(input int unsigned lat);
    return (clog2(lat) < 1) ? 1 : clog2(lat);
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Tracks occupancy of the multi-cycle multiply/divide unit.
//   A start in cycle T keeps busy_o high for cycles T+1 .. T+MDU_LATENCY.
//   A start while already BUSY is ignored (no restart).
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high
//   start_i  in   valid mult/div in EX this cycle
//   busy_o   out  FSM is in BUSY
module mdu_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic busy_o
);

  localparam int unsigned CW = mdu_cnt_w(MDU_LATENCY);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MDU_LATENCY - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = LOAD_VAL;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == BUSY);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
//   Hazard detection and stall sequencing for the 5-stage MIPS pipeline.
//   Stalls only where forwarding cannot cover a dependency:
//     load_use : load in EX feeding the instruction in ID
//     br_ex    : branch in ID depending on any register write in EX
//     br_mem   : branch in ID depending on a load in MEM
//     mdu_haz  : MDU op / mfhi-mflo in ID while the MDU is (or is becoming) busy
//   Control outputs are combinational; stall_count is a saturating counter.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_rs, id_rt, id_use_rs/rt      ID source registers and their use flags
//   id_branch, id_mdu_op,
//   id_mdu_read, branch_taken       ID instruction class / branch outcome
//   ex_mem_read, ex_reg_write,
//   ex_write_reg, ex_mdu_start      EX-stage destination info and MDU start
//   mem_mem_read, mem_write_reg     MEM-stage load destination
//   pc_write, ifid_write            PC and IF-ID enables
//   ifid_flush, idex_bubble         IF-ID clear, ID-EX nop insert
//   mdu_busy                        MDU occupancy
//   stall_count                     saturating count of stall cycles
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             id_mdu_op,
  input  logic             id_mdu_read,
  input  logic             branch_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_write_reg,
  input  logic             ex_mdu_start,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_count
);

  logic             ex_match, mem_match;
  logic             load_use, br_ex, br_mem, mdu_haz, stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  mdu_sequencer #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_mdu_seq (
    .clk    (clk),
    .reset  (reset),
    .start_i(ex_mdu_start),
    .busy_o (mdu_busy)
  );

  // $0 is hardwired zero, so a write to it never creates a dependency.
  always_comb begin
    ex_match  = (ex_write_reg != 5'd0) &&
                ((id_use_rs && (ex_write_reg == id_rs)) ||
                 (id_use_rt && (ex_write_reg == id_rt)));
    mem_match = (mem_write_reg != 5'd0) &&
                ((id_use_rs && (mem_write_reg == id_rs)) ||
                 (id_use_rt && (mem_write_reg == id_rt)));
  end

  always_comb begin
    load_use = ex_mem_read && ex_match;
    br_ex    = id_branch && ex_reg_write && ex_match;
    br_mem   = id_branch && mem_mem_read && mem_match;
    // ex_mdu_start is included so the op entering the MDU this cycle
    // already blocks a dependent ID instruction.
    mdu_haz  = (id_mdu_op || id_mdu_read) && (mdu_busy || ex_mdu_start);
    stall    = load_use || br_ex || br_mem || mdu_haz;
  end

  // Reset looks like a stall to the pipeline; branch_taken is ignored
  // whenever the ID instruction is being held.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (reset || stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush  = branch_taken;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall sequencer for the 5-stage MIPS core. Detects load-use and branch-operand hazards at ID, and tracks occupancy of the multi-cycle multiply/divide unit (MDU) with a small FSM. Drives the PC/IF-ID write enables, the IF-ID flush and the ID-EX bubble insert. Counts stall cycles for performance analysis. Complements the write-back and EX/MEM forwarding paths: it stalls only where forwarding cannot cover the dependency.

## Interface
- MDU_LATENCY, 32, cycles the MDU stays busy after the start cycle (≥1)
- CNT_W, 32, width of the stall counter

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- id_rs, id_rt  in  5  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  in  1  instruction in ID actually reads rs / rt
- id_branch  in  1  ID holds a branch; operands are compared in ID
- id_mdu_op  in  1  ID holds mult/div/mthi/mtlo
- id_mdu_read  in  1  ID holds mfhi/mflo
- branch_taken  in  1  branch in ID resolved taken this cycle
- ex_mem_read, ex_reg_write  in  1  EX-stage instruction is a load / writes a register
- ex_write_reg  in  5  EX-stage destination register
- mem_mem_read  in  1  MEM-stage instruction is a load
- mem_write_reg  in  5  MEM-stage destination register
- ex_mdu_start  in  1  a valid mult/div is in EX this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF-ID register enable
- ifid_flush  out  1  clear IF-ID to nop
- idex_bubble  out  1  load nop into ID-EX
- mdu_busy  out  1  MDU FSM in BUSY
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- match(r) = r != 0 && ((id_use_rs && r == id_rs) || (id_use_rt && r == id_rt)).
- Hazard terms:
  - load_use = ex_mem_read && match(ex_write_reg).
  - br_ex = id_branch && ex_reg_write && match(ex_write_reg).
  - br_mem = id_branch && mem_mem_read && match(mem_write_reg).
  - mdu_haz = (id_mdu_op || id_mdu_read) && (mdu_busy || ex_mdu_start).
- stall = any of the four hazard terms.
- When stall = 1: pc_write = 0, ifid_write = 0, idex_bubble = 1, ifid_flush = 0. branch_taken is ignored while stalled.
- When stall = 0: pc_write = 1, ifid_write = 1, idex_bubble = 0, ifid_flush = branch_taken.
- MDU FSM states:
  - IDLE: on ex_mdu_start, load counter with MDU_LATENCY-1 and go to BUSY.
  - BUSY: if counter == 0, go to IDLE; otherwise decrement.
  - ex_mdu_start while BUSY is ignored, with no restart. It cannot occur legally because mdu_haz stalls ID; the bench flags it with an assertion.
- stall_count increments by 1 on every cycle with stall = 1 and reset = 0. It saturates at all-ones and does not wrap.

## Timing
- Hazard outputs are combinational from the current inputs and FSM state, so a stall takes effect in the same cycle.
- MDU: ex_mdu_start in cycle T gives mdu_busy = 1 in cycles T+1 … T+MDU_LATENCY and mdu_busy = 0 from T+MDU_LATENCY+1. An mfhi in ID is stalled through T+MDU_LATENCY and issues in T+MDU_LATENCY+1.
- Load-use costs exactly 1 stall cycle: the load moves to MEM, and forwarding then covers the dependency.
- A branch dependent on an ALU op in EX costs 1 cycle.
- A branch dependent on a load costs 2 cycles: br_ex, then br_mem.
- While reset = 1: pc_write = 0, ifid_write = 0, idex_bubble = 1, ifid_flush = 0, regardless of other inputs.
- After the reset edge: FSM is IDLE, counter = 0, mdu_busy = 0, stall_count = 0.
- Reset asserted mid-BUSY returns the FSM to IDLE on that edge.
- Simultaneous hazards produce a single stall, counted once per cycle.

## Structure
- Package hazard_pkg: MDU state enum (IDLE, BUSY) and the counter-width function clog2(MDU_LATENCY).
- One sub-module, mdu_sequencer: FSM plus down-counter, outputs mdu_busy.
- The top level holds the hazard comparators, output muxing and stall_count.

## Test plan
- Load-use: ex_mem_read = 1, ex_write_reg = 8, id_rs = 8, id_use_rs = 1 → pc_write = 0, idex_bubble = 1 for one cycle; stall_count = 1.
- Register $0 never hazards: ex_mem_read = 1, ex_write_reg = 0, id_rs = 0 → stall = 0.
- Branch on a loaded register (rt = 9):
  - Cycle 1: br_ex.
  - Cycle 2: br_mem.
  - Result: 2 stall cycles. branch_taken = 1 during them gives ifid_flush = 0; in cycle 3 it gives ifid_flush = 1.
- MDU with MDU_LATENCY = 4: ex_mdu_start at T, id_mdu_read = 1 held → mdu_busy high T+1…T+4, stall T…T+4, pc_write = 1 at T+5.
- Reset at T+2 during BUSY → mdu_busy = 0 at T+3, stall_count = 0, outputs held in reset state while reset = 1.
- Saturation with CNT_W = 4: 20 consecutive stall cycles → stall_count = 15.
